// File: rtl/fifo_pkg.sv
// Purpose: shared defaults for the RAM-backed FIFO (word width, address width, depth).
// Latency: n/a, constants only.
// Backpressure: n/a.
package fifo_pkg;

    localparam int DW    = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Purpose: upstream/downstream valid-ready bus plus fill level for ram_fifo_ctrl.
// Latency: n/a, wires only.
// Backpressure: in_ready stalls the producer, out_ready stalls the FIFO output.
interface ram_fifo_ctrl_if #(
    parameter int DW = fifo_pkg::DW,
    parameter int AW = fifo_pkg::AW
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;

    // Environment side: produces input words and consumes output words.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  level
    );

    // FIFO side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output level
    );

endinterface

// File: rtl/fifo_mem.sv
// Purpose: DEPTH x DW storage array, one write port and one registered read port.
// Latency: read data valid one cycle after re.
// Backpressure: none; rdata holds whenever re is low.
module fifo_mem #(
    parameter int DW = fifo_pkg::DW,
    parameter int AW = fifo_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; only reloads on a read request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Purpose: FIFO controller over fifo_mem with a registered output stage (4 RAM words + 1 output word).
// Latency: push in cycle t into empty FIFO appears on out_data in t+2; 1 word/cycle sustained.
// Backpressure: in_ready drops when RAM holds 4 words; out_valid/out_data hold while out_ready is low.
module ram_fifo_ctrl #(
    parameter int DW = fifo_pkg::DW,
    parameter int AW = fifo_pkg::AW
) (
    input  logic           clk,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);

    localparam int          DEPTH_L   = 2 ** AW;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH_L);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    // Pointers carry one extra bit so full (count == DEPTH) and empty differ.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   ram_count;
    logic          out_valid_q;
    logic          push;
    logic          fetch;
    logic [DW-1:0] rdata;

    assign ram_count = wr_ptr - rd_ptr;

    // in_ready looks only at registered state, never at out_ready.
    assign bus.in_ready = !rst && (ram_count != FULL_CNT);
    assign push         = bus.in_valid && bus.in_ready;

    // Refill the output register when it is empty or being drained. ram_count
    // only reflects earlier pushes, so a fetch never hits this cycle's write slot.
    assign fetch = !rst && (ram_count != '0) && (!out_valid_q || bus.out_ready);

    // Pointer and output-valid state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (fetch) begin
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.in_data),
        .re    (fetch),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = rdata;
    assign bus.level     = ram_count + {{AW{1'b0}}, out_valid_q};

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Purpose: directed and randomised checks of ram_fifo_ctrl against hand-derived values and a queue.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: exercised with held out_ready, full FIFO and random stalls.
module tb_ram_fifo_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   q[$];

    ram_fifo_ctrl_if #(.DW(4), .AW(2)) bus ();

    ram_fifo_ctrl #(.DW(4), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] word(input int i);
        word = 4'((i * 7 + 2) & 15);
    endfunction

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_level", 32'(bus.level), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 0);
        chk("post_rst_level", 32'(bus.level), 0);

        // Single word latency
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h3;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("lat_t1_level", 32'(bus.level), 1);
        chk("lat_t1_out_valid", 32'(bus.out_valid), 0);
        tick();
        chk("lat_t2_out_valid", 32'(bus.out_valid), 1);
        chk("lat_t2_out_data", 32'(bus.out_data), 3);
        chk("lat_t2_level", 32'(bus.level), 1);
        tick();
        chk("lat_t3_out_valid", 32'(bus.out_valid), 0);
        chk("lat_t3_level", 32'(bus.level), 0);

        // Fill with downstream stalled: 5 accepted, 6th held off
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(k);
            chk($sformatf("fill_in_ready_%0d", k), 32'(bus.in_ready), (k <= 5) ? 1 : 0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("full_level", 32'(bus.level), 5);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_out_valid", 32'(bus.out_valid), 1);
        chk("full_out_data", 32'(bus.out_data), 1);
        tick();
        tick();
        chk("hold_out_data", 32'(bus.out_data), 1);
        chk("hold_level", 32'(bus.level), 5);

        // Drain from full in consecutive cycles
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("drain_valid_%0d", k), 32'(bus.out_valid), 1);
            chk($sformatf("drain_data_%0d", k), 32'(bus.out_data), k);
            tick();
        end
        chk("drain_end_valid", 32'(bus.out_valid), 0);
        chk("drain_end_level", 32'(bus.level), 0);
        bus.out_ready = 1'b0;

        // Streaming 20 words, pointers wrap
        for (int i = 0; i < 22; i++) begin
            bus.in_valid  = (i < 20);
            bus.in_data   = word(i);
            bus.out_ready = 1'b1;
            if (i < 20) chk($sformatf("stream_in_ready_%0d", i), 32'(bus.in_ready), 1);
            if (i >= 2) begin
                chk($sformatf("stream_valid_%0d", i), 32'(bus.out_valid), 1);
                chk($sformatf("stream_data_%0d", i), 32'(bus.out_data), 32'(word(i - 2)));
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("stream_end_valid", 32'(bus.out_valid), 0);
        chk("stream_end_level", 32'(bus.level), 0);

        // Reset mid-operation
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(4'hA + k);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("mid_pre_level", 32'(bus.level), 3);
        chk("mid_pre_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_post_valid", 32'(bus.out_valid), 0);
        chk("mid_post_level", 32'(bus.level), 0);
        chk("mid_post_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h9;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("mid_new_valid", 32'(bus.out_valid), 1);
        chk("mid_new_data", 32'(bus.out_data), 9);
        tick();
        chk("mid_after_valid", 32'(bus.out_valid), 0);
        chk("mid_after_level", 32'(bus.level), 0);

        // Random stalls against a reference queue
        q.delete();
        for (int n = 0; n < 1000; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            chk("rnd_level", 32'(bus.level), 32'(q.size()));
            chk("rnd_in_ready", 32'(bus.in_ready),
                ((q.size() - int'(bus.out_valid)) != 4) ? 1 : 0);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("rnd_underflow", 1, 0);
                else chk("rnd_data", 32'(bus.out_data), 32'(q.pop_front()));
            end
            if (bus.in_valid && bus.in_ready) q.push_back(int'(bus.in_data));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            if (bus.out_valid) chk("rnd_drain_data", 32'(bus.out_data), 32'(q.pop_front()));
            tick();
        end
        chk("rnd_drain_left", 32'(q.size()), 0);
        chk("rnd_end_valid", 32'(bus.out_valid), 0);
        chk("rnd_end_level", 32'(bus.level), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 4, meaning data word width.
REQ-002 The block SHALL have parameter AW, default 2, meaning storage address width; storage depth is 2**AW = 4.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream word is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the offered word this cycle.
REQ-007 The block SHALL have port in_data, input, DW, meaning the upstream word.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_data holds a valid word.
REQ-009 The block SHALL have port out_ready, input, 1, meaning downstream takes out_data this cycle.
REQ-010 The block SHALL have port out_data, output, DW, meaning the downstream word, driven directly from the storage read register.
REQ-011 The block SHALL have port level, output, AW+1, meaning the number of words held in storage plus the output register (0..5).

Function
REQ-012 The block SHALL push when in_valid && in_ready: write in_data at wr_ptr[AW-1:0], then wr_ptr+1.
REQ-013 The block SHALL drive in_ready = !rst && (ram_count != 4), combinationally from registered state only; no same-cycle dependence on out_ready.
REQ-014 The block SHALL issue a fetch when ram_count != 0 && (!out_valid || out_ready): read at rd_ptr[AW-1:0], then rd_ptr+1.
REQ-015 The fetched word SHALL appear on out_data with out_valid=1 exactly one cycle after the fetch.
REQ-016 out_valid next SHALL be 1 if a fetch is issued; otherwise 0 if out_ready; otherwise unchanged.
REQ-017 out_data SHALL hold its value whenever no fetch is issued, including while out_valid=1 && out_ready=0.
REQ-018 A word pushed in cycle t into an empty block SHALL be fetched in t+1 and present on out_valid in t+2; sustained throughput SHALL be one word per cycle.
REQ-019 Pointers SHALL be AW+1 bits and wrap modulo 8; ram_count = wr_ptr - rd_ptr (modulo 8), range 0..4.
REQ-020 A simultaneous push and fetch SHALL leave ram_count unchanged and target different addresses; no read/write collision shall occur.
REQ-021 A fetch SHALL NOT read the entry being written in the same cycle (ram_count counts only registered pushes).
REQ-022 level SHALL equal ram_count + out_valid.
REQ-023 Word order SHALL be strictly FIFO; no word is dropped or duplicated.

Reset
REQ-024 While rst=1, the block SHALL clear wr_ptr, rd_ptr, out_valid and out_data to 0 at each clock edge, and drive in_ready=0.
REQ-025 Reset mid-operation SHALL discard all stored and in-flight words; storage array contents SHALL NOT be cleared.
REQ-026 In the first cycle after rst falls, the block SHALL show in_ready=1, out_valid=0 and level=0.

Structure
REQ-027 A shared package fifo_pkg SHALL hold DW, AW and DEPTH=2**AW defaults.
REQ-028 Storage SHALL be sub-module fifo_mem: DEPTH x DW array, a write port (we, waddr, wdata) and a registered read port (re, raddr, rdata); rdata updates only when re=1 and resets to 0.
REQ-029 Pointer, count and handshake logic SHALL reside in ram_fifo_ctrl.

Verification
REQ-030 Bench SHALL cover: reset, then push 0x3 at t with out_ready=1 -> out_valid=1, out_data=0x3 at t+2, level=1 at t+1.
REQ-031 Bench SHALL cover: out_ready=0, push 0x1..0x6 back-to-back -> 5 accepted, in_ready=0 from the cycle level=5, 0x6 held off; out_data=0x1.
REQ-032 Bench SHALL cover: from full, out_ready=1 for 5 cycles -> out_data 0x1,0x2,0x3,0x4,0x5 in consecutive cycles, then out_valid=0, level=0.
REQ-033 Bench SHALL cover: continuous push and pop of 20 words with in_valid and out_ready both 1 -> 1 word/cycle, order preserved, pointers wrap at 8 with no loss.
REQ-034 Bench SHALL cover: rst=1 for one cycle while level=3 and out_valid=1 -> next cycle out_valid=0, level=0, in_ready=1; the next push returns only the new word.
REQ-035 Bench SHALL cover: random in_valid/out_ready stalls for 1000 cycles vs. a reference queue -> identical output sequence, level always 0..5.
